// File: rtl/rob_pkg.sv
// Shared sizing and entry layout for the reorder buffer.
package rob_pkg;

  localparam int ROB_DEPTH = 8;
  localparam int ROB_TAG_W = $clog2(ROB_DEPTH);

  typedef struct packed {
    logic        valid;
    logic        done;
    logic        writes;
    logic [4:0]  rd;
    logic [31:0] data;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Issue, CDB, query, flush and commit signals of the reorder buffer.
interface reorder_buffer_if import rob_pkg::*; #(parameter int TAG_W = ROB_TAG_W);

  logic             i_alloc_valid;
  logic [4:0]       i_alloc_rd;
  logic             i_alloc_writes;
  logic             o_alloc_ready;
  logic [TAG_W-1:0] o_alloc_tag;
  logic             i_cdb_valid;
  logic [TAG_W-1:0] i_cdb_tag;
  logic [31:0]      i_cdb_data;
  logic [TAG_W-1:0] i_q_tag;
  logic             o_q_done;
  logic [31:0]      o_q_data;
  logic             i_flush;
  logic             o_commit_valid;
  logic [TAG_W-1:0] o_commit_tag;
  logic [4:0]       o_commit_rd;
  logic             o_commit_RegWrite;
  logic [31:0]      o_commit_data;
  logic [TAG_W:0]   o_count;

  modport master (
    output i_alloc_valid, i_alloc_rd, i_alloc_writes, i_cdb_valid, i_cdb_tag,
           i_cdb_data, i_q_tag, i_flush,
    input  o_alloc_ready, o_alloc_tag, o_q_done, o_q_data, o_commit_valid,
           o_commit_tag, o_commit_rd, o_commit_RegWrite, o_commit_data, o_count
  );

  modport slave (
    input  i_alloc_valid, i_alloc_rd, i_alloc_writes, i_cdb_valid, i_cdb_tag,
           i_cdb_data, i_q_tag, i_flush,
    output o_alloc_ready, o_alloc_tag, o_q_done, o_q_data, o_commit_valid,
           o_commit_tag, o_commit_rd, o_commit_RegWrite, o_commit_data, o_count
  );

endinterface

// File: rtl/rob_ptr.sv
// Wrapping ring pointer; wraps naturally because the depth is a power of two.
module rob_ptr #(
  parameter int TAG_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [TAG_W-1:0] o_ptr
);

  logic [TAG_W-1:0] r_ptr;

  always_ff @(posedge clk) begin
    if (!reset || i_clear) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= r_ptr + TAG_W'(1);
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/reorder_buffer.sv
// In-order commit buffer: issue allocates at tail, CDB completes entries,
// the head retires one per cycle straight onto the register-file write port.
module reorder_buffer import rob_pkg::*; #(
  parameter int DEPTH = ROB_DEPTH,
  parameter int TAG_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  reorder_buffer_if.slave  bus
);

  rob_entry_t       r_entries [DEPTH];
  logic [TAG_W:0]   r_count;
  logic [TAG_W-1:0] w_head;
  logic [TAG_W-1:0] w_tail;
  rob_entry_t       w_head_e;
  rob_entry_t       w_q_e;
  logic             w_alloc_ready;
  logic             w_alloc_fire;
  logic             w_commit;
  logic             w_bypass;
  logic             w_q_done;

  assign w_head_e      = r_entries[w_head];
  assign w_q_e         = r_entries[bus.i_q_tag];
  assign w_alloc_ready = (r_count < (TAG_W+1)'(DEPTH));
  assign w_alloc_fire  = bus.i_alloc_valid && w_alloc_ready && !bus.i_flush;
  assign w_commit      = w_head_e.valid && w_head_e.done && !bus.i_flush && reset;
  assign w_bypass      = bus.i_cdb_valid && (bus.i_cdb_tag == bus.i_q_tag);
  assign w_q_done      = w_q_e.valid && (w_q_e.done || w_bypass);

  rob_ptr #(.TAG_W(TAG_W)) u_head (
    .clk     (clk),
    .reset   (reset),
    .i_clear (bus.i_flush),
    .i_inc   (w_commit),
    .o_ptr   (w_head)
  );

  rob_ptr #(.TAG_W(TAG_W)) u_tail (
    .clk     (clk),
    .reset   (reset),
    .i_clear (bus.i_flush),
    .i_inc   (w_alloc_fire),
    .o_ptr   (w_tail)
  );

  // Alloc only targets a free slot, so it never collides with the CDB or commit.
  always_ff @(posedge clk) begin
    if (!reset || bus.i_flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_entries[i] <= '0;
      end
      r_count <= '0;
    end else begin
      if (bus.i_cdb_valid && r_entries[bus.i_cdb_tag].valid) begin
        r_entries[bus.i_cdb_tag].done <= 1'b1;
        r_entries[bus.i_cdb_tag].data <= bus.i_cdb_data;
      end
      if (w_commit) begin
        r_entries[w_head].valid <= 1'b0;
      end
      if (w_alloc_fire) begin
        r_entries[w_tail] <= '{valid: 1'b1, done: 1'b0, writes: bus.i_alloc_writes,
                               rd: bus.i_alloc_rd, data: 32'd0};
      end
      unique case ({w_alloc_fire, w_commit})
        2'b10:   r_count <= r_count + (TAG_W+1)'(1);
        2'b01:   r_count <= r_count - (TAG_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.o_alloc_ready     = w_alloc_ready;
  assign bus.o_alloc_tag       = w_tail;
  assign bus.o_count           = r_count;
  assign bus.o_commit_valid    = w_commit;
  assign bus.o_commit_tag      = w_head;
  assign bus.o_commit_rd       = w_commit ? w_head_e.rd : 5'd0;
  assign bus.o_commit_data     = w_commit ? w_head_e.data : 32'd0;
  assign bus.o_commit_RegWrite = w_commit && w_head_e.writes && (w_head_e.rd != 5'd0);
  assign bus.o_q_done          = w_q_done;
  assign bus.o_q_data          = !w_q_done ? 32'd0 : (w_bypass ? bus.i_cdb_data : w_q_e.data);

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed and randomized checks of reorder_buffer against a program-order queue model.
module tb_reorder_buffer;

  localparam int DEPTH = 8;
  localparam int TAG_W = 3;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  reorder_buffer_if #(.TAG_W(TAG_W)) bus();

  reorder_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          tag;
    logic [4:0]  rd;
    logic        writes;
    logic        done;
    logic [31:0] data;
  } m_ent_t;

  // In-flight instructions, oldest first; the tag counter mirrors issue order.
  m_ent_t m_q[$];
  int     m_tail = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic idle_inputs();
    bus.i_alloc_valid  = 1'b0;
    bus.i_alloc_rd     = '0;
    bus.i_alloc_writes = 1'b0;
    bus.i_cdb_valid    = 1'b0;
    bus.i_cdb_tag      = '0;
    bus.i_cdb_data     = '0;
    bus.i_q_tag        = '0;
    bus.i_flush        = 1'b0;
  endtask

  // Advance the model by one clock using the inputs currently applied, then clock the DUT.
  task automatic tick();
    bit     do_commit;
    bit     can_alloc;
    m_ent_t e;
    if (!reset || bus.i_flush) begin
      m_q.delete();
      m_tail = 0;
    end else begin
      do_commit = (m_q.size() > 0) && m_q[0].done;
      can_alloc = m_q.size() < DEPTH;
      if (bus.i_cdb_valid) begin
        foreach (m_q[i]) begin
          if (m_q[i].tag == int'(bus.i_cdb_tag)) begin
            m_q[i].done = 1'b1;
            m_q[i].data = bus.i_cdb_data;
          end
        end
      end
      if (do_commit) void'(m_q.pop_front());
      if (bus.i_alloc_valid && can_alloc) begin
        e.tag = m_tail; e.rd = bus.i_alloc_rd; e.writes = bus.i_alloc_writes;
        e.done = 1'b0; e.data = 32'd0;
        m_q.push_back(e);
        m_tail = (m_tail + 1) % DEPTH;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    idle_inputs();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    checks++; if (bus.o_alloc_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_alloc_ready: got %0h want 1", bus.o_alloc_ready); end
    checks++; if (bus.o_alloc_tag !== 3'd0) begin errors++; $display("[TB] FAIL reset_alloc_tag: got %0h want 0", bus.o_alloc_tag); end
    checks++; if (bus.o_count !== 4'd0) begin errors++; $display("[TB] FAIL reset_count: got %0h want 0", bus.o_count); end
    checks++; if (bus.o_commit_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_commit_valid: got %0h want 0", bus.o_commit_valid); end
    checks++; if (bus.o_commit_RegWrite !== 1'b0) begin errors++; $display("[TB] FAIL reset_regwrite: got %0h want 0", bus.o_commit_RegWrite); end
    checks++; if (bus.o_commit_rd !== 5'd0) begin errors++; $display("[TB] FAIL reset_commit_rd: got %0h want 0", bus.o_commit_rd); end
    checks++; if (bus.o_commit_data !== 32'd0) begin errors++; $display("[TB] FAIL reset_commit_data: got %0h want 0", bus.o_commit_data); end
    checks++; if (bus.o_commit_tag !== 3'd0) begin errors++; $display("[TB] FAIL reset_commit_tag: got %0h want 0", bus.o_commit_tag); end
    checks++; if (bus.o_q_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_q_done: got %0h want 0", bus.o_q_done); end
  endtask

  task automatic test_single();
    restart();
    bus.i_alloc_valid = 1'b1; bus.i_alloc_rd = 5'd5; bus.i_alloc_writes = 1'b1;
    #1;
    checks++; if (bus.o_alloc_tag !== 3'd0) begin errors++; $display("[TB] FAIL single_alloc_tag: got %0h want 0", bus.o_alloc_tag); end
    tick();
    idle_inputs();
    bus.i_cdb_valid = 1'b1; bus.i_cdb_tag = 3'd0; bus.i_cdb_data = 32'hDEADBEEF; bus.i_q_tag = 3'd0;
    #1;
    checks++; if (bus.o_commit_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_no_bypass: got %0h want 0", bus.o_commit_valid); end
    checks++; if (bus.o_q_done !== 1'b1) begin errors++; $display("[TB] FAIL single_q_done_bypass: got %0h want 1", bus.o_q_done); end
    checks++; if (bus.o_q_data !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL single_q_data_bypass: got %0h want deadbeef", bus.o_q_data); end
    checks++; if (bus.o_count !== 4'd1) begin errors++; $display("[TB] FAIL single_count1: got %0h want 1", bus.o_count); end
    tick();
    idle_inputs();
    #1;
    checks++; if (bus.o_commit_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_commit_valid: got %0h want 1", bus.o_commit_valid); end
    checks++; if (bus.o_commit_rd !== 5'd5) begin errors++; $display("[TB] FAIL single_commit_rd: got %0h want 5", bus.o_commit_rd); end
    checks++; if (bus.o_commit_RegWrite !== 1'b1) begin errors++; $display("[TB] FAIL single_regwrite: got %0h want 1", bus.o_commit_RegWrite); end
    checks++; if (bus.o_commit_data !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL single_commit_data: got %0h want deadbeef", bus.o_commit_data); end
    tick();
    checks++; if (bus.o_count !== 4'd0) begin errors++; $display("[TB] FAIL single_count0: got %0h want 0", bus.o_count); end
    checks++; if (bus.o_commit_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_empty_commit: got %0h want 0", bus.o_commit_valid); end
  endtask

  task automatic test_out_of_order();
    int order[3] = '{2, 1, 0};
    restart();
    for (int t = 0; t < 3; t++) begin
      bus.i_alloc_valid = 1'b1; bus.i_alloc_rd = 5'(t + 10); bus.i_alloc_writes = 1'b1;
      tick();
    end
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      bus.i_cdb_valid = 1'b1; bus.i_cdb_tag = 3'(order[k]); bus.i_cdb_data = 32'h100 + 32'(order[k]);
      #1;
      checks++; if (bus.o_commit_valid !== 1'b0) begin errors++; $display("[TB] FAIL ooo_wait_head%0d: got %0h want 0", k, bus.o_commit_valid); end
      tick();
    end
    idle_inputs();
    for (int t = 0; t < 3; t++) begin
      #1;
      checks++; if (bus.o_commit_valid !== 1'b1) begin errors++; $display("[TB] FAIL ooo_commit_valid%0d: got %0h want 1", t, bus.o_commit_valid); end
      checks++; if (bus.o_commit_tag !== 3'(t)) begin errors++; $display("[TB] FAIL ooo_commit_tag%0d: got %0h want %0h", t, bus.o_commit_tag, t); end
      checks++; if (bus.o_commit_data !== 32'h100 + 32'(t)) begin errors++; $display("[TB] FAIL ooo_commit_data%0d: got %0h want %0h", t, bus.o_commit_data, 32'h100 + t); end
      tick();
    end
    checks++; if (bus.o_count !== 4'd0) begin errors++; $display("[TB] FAIL ooo_count: got %0h want 0", bus.o_count); end
  endtask

  task automatic test_full_wrap();
    restart();
    for (int i = 0; i < DEPTH; i++) begin
      bus.i_alloc_valid = 1'b1; bus.i_alloc_rd = 5'(i + 1); bus.i_alloc_writes = 1'b1;
      tick();
    end
    bus.i_alloc_rd = 5'd31;
    #1;
    checks++; if (bus.o_alloc_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_ready: got %0h want 0", bus.o_alloc_ready); end
    checks++; if (bus.o_count !== 4'd8) begin errors++; $display("[TB] FAIL full_count: got %0h want 8", bus.o_count); end
    tick();
    checks++; if (bus.o_count !== 4'd8) begin errors++; $display("[TB] FAIL full_ignored: got %0h want 8", bus.o_count); end
    bus.i_cdb_valid = 1'b1; bus.i_cdb_tag = 3'd0; bus.i_cdb_data = 32'hA5A5;
    tick();
    bus.i_cdb_valid = 1'b0; bus.i_alloc_rd = 5'd20;
    #1;
    checks++; if (bus.o_commit_valid !== 1'b1) begin errors++; $display("[TB] FAIL full_commit: got %0h want 1", bus.o_commit_valid); end
    checks++; if (bus.o_alloc_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_no_reuse: got %0h want 0", bus.o_alloc_ready); end
    tick();
    checks++; if (bus.o_count !== 4'd7) begin errors++; $display("[TB] FAIL full_count7: got %0h want 7", bus.o_count); end
    checks++; if (bus.o_alloc_ready !== 1'b1) begin errors++; $display("[TB] FAIL full_ready_again: got %0h want 1", bus.o_alloc_ready); end
    checks++; if (bus.o_alloc_tag !== 3'd0) begin errors++; $display("[TB] FAIL wrap_tag0: got %0h want 0", bus.o_alloc_tag); end
    tick();
    bus.i_alloc_valid = 1'b0;
    #1;
    checks++; if (bus.o_count !== 4'd8) begin errors++; $display("[TB] FAIL wrap_count8: got %0h want 8", bus.o_count); end
    checks++; if (bus.o_alloc_tag !== 3'd1) begin errors++; $display("[TB] FAIL wrap_tag1: got %0h want 1", bus.o_alloc_tag); end
  endtask

  task automatic test_rd_zero();
    restart();
    bus.i_alloc_valid = 1'b1; bus.i_alloc_rd = 5'd0; bus.i_alloc_writes = 1'b1;
    tick();
    bus.i_alloc_rd = 5'd7; bus.i_alloc_writes = 1'b0;
    tick();
    idle_inputs();
    bus.i_cdb_valid = 1'b1; bus.i_cdb_tag = 3'd0; bus.i_cdb_data = 32'h1234;
    tick();
    bus.i_cdb_tag = 3'd1; bus.i_cdb_data = 32'h5678;
    #1;
    checks++; if (bus.o_commit_valid !== 1'b1) begin errors++; $display("[TB] FAIL rd0_commit: got %0h want 1", bus.o_commit_valid); end
    checks++; if (bus.o_commit_RegWrite !== 1'b0) begin errors++; $display("[TB] FAIL rd0_regwrite: got %0h want 0", bus.o_commit_RegWrite); end
    checks++; if (bus.o_commit_data !== 32'h1234) begin errors++; $display("[TB] FAIL rd0_data: got %0h want 1234", bus.o_commit_data); end
    tick();
    idle_inputs();
    #1;
    checks++; if (bus.o_commit_valid !== 1'b1) begin errors++; $display("[TB] FAIL nowrite_commit: got %0h want 1", bus.o_commit_valid); end
    checks++; if (bus.o_commit_RegWrite !== 1'b0) begin errors++; $display("[TB] FAIL nowrite_regwrite: got %0h want 0", bus.o_commit_RegWrite); end
    checks++; if (bus.o_commit_rd !== 5'd7) begin errors++; $display("[TB] FAIL nowrite_rd: got %0h want 7", bus.o_commit_rd); end
    tick();
  endtask

  task automatic test_flush();
    restart();
    for (int i = 0; i < 4; i++) begin
      bus.i_alloc_valid = 1'b1; bus.i_alloc_rd = 5'(i + 1); bus.i_alloc_writes = 1'b1;
      tick();
    end
    idle_inputs();
    bus.i_cdb_valid = 1'b1; bus.i_cdb_tag = 3'd0; bus.i_cdb_data = 32'h77;
    tick();
    bus.i_flush = 1'b1; bus.i_alloc_valid = 1'b1; bus.i_cdb_tag = 3'd1; bus.i_cdb_data = 32'h99;
    #1;
    checks++; if (bus.o_commit_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_commit: got %0h want 0", bus.o_commit_valid); end
    tick();
    idle_inputs();
    bus.i_cdb_valid = 1'b1; bus.i_cdb_tag = 3'd1; bus.i_cdb_data = 32'h55; bus.i_q_tag = 3'd1;
    #1;
    checks++; if (bus.o_count !== 4'd0) begin errors++; $display("[TB] FAIL flush_count: got %0h want 0", bus.o_count); end
    checks++; if (bus.o_alloc_tag !== 3'd0) begin errors++; $display("[TB] FAIL flush_alloc_tag: got %0h want 0", bus.o_alloc_tag); end
    checks++; if (bus.o_q_done !== 1'b0) begin errors++; $display("[TB] FAIL flush_stale_query: got %0h want 0", bus.o_q_done); end
    tick();
    idle_inputs();
    #1;
    checks++; if (bus.o_commit_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_stale_cdb: got %0h want 0", bus.o_commit_valid); end
    checks++; if (bus.o_count !== 4'd0) begin errors++; $display("[TB] FAIL flush_count_after: got %0h want 0", bus.o_count); end
  endtask

  task automatic test_random();
    logic        e_cv, e_rw, e_qd;
    logic [4:0]  e_rd;
    logic [31:0] e_data, e_qdata;
    int          e_tag;
    restart();
    for (int cyc = 0; cyc < 600; cyc++) begin
      reset              = ($urandom_range(0, 79) != 0);
      bus.i_flush        = ($urandom_range(0, 39) == 0);
      bus.i_alloc_valid  = ($urandom_range(0, 9) < 6);
      bus.i_alloc_rd     = 5'($urandom);
      bus.i_alloc_writes = 1'($urandom);
      bus.i_cdb_valid    = ($urandom_range(0, 2) != 0);
      bus.i_cdb_data     = $urandom;
      if (m_q.size() > 0 && $urandom_range(0, 4) != 0)
        bus.i_cdb_tag = 3'(m_q[$urandom_range(0, m_q.size() - 1)].tag);
      else
        bus.i_cdb_tag = 3'($urandom);
      bus.i_q_tag = ($urandom_range(0, 1) == 0) ? bus.i_cdb_tag : 3'($urandom);
      #1;
      e_cv = reset && !bus.i_flush && (m_q.size() > 0) && m_q[0].done;
      e_rw = 1'b0; e_rd = 5'd0; e_data = 32'd0;
      if (e_cv) begin
        e_rw = m_q[0].writes && (m_q[0].rd != 5'd0);
        e_rd = m_q[0].rd; e_data = m_q[0].data;
      end
      e_tag = (m_q.size() > 0) ? m_q[0].tag : m_tail;
      e_qd = 1'b0; e_qdata = 32'd0;
      foreach (m_q[i]) begin
        if (m_q[i].tag == int'(bus.i_q_tag)) begin
          if (bus.i_cdb_valid && bus.i_cdb_tag == bus.i_q_tag) begin
            e_qd = 1'b1; e_qdata = bus.i_cdb_data;
          end else if (m_q[i].done) begin
            e_qd = 1'b1; e_qdata = m_q[i].data;
          end
        end
      end
      checks++; if (bus.o_alloc_ready !== (m_q.size() < DEPTH)) begin errors++; $display("[TB] FAIL rnd_alloc_ready@%0d: got %0h want %0h", cyc, bus.o_alloc_ready, m_q.size() < DEPTH); end
      checks++; if (bus.o_alloc_tag !== 3'(m_tail)) begin errors++; $display("[TB] FAIL rnd_alloc_tag@%0d: got %0h want %0h", cyc, bus.o_alloc_tag, m_tail); end
      checks++; if (bus.o_count !== 4'(m_q.size())) begin errors++; $display("[TB] FAIL rnd_count@%0d: got %0h want %0h", cyc, bus.o_count, m_q.size()); end
      checks++; if (bus.o_commit_valid !== e_cv) begin errors++; $display("[TB] FAIL rnd_commit_valid@%0d: got %0h want %0h", cyc, bus.o_commit_valid, e_cv); end
      checks++; if (bus.o_commit_tag !== 3'(e_tag)) begin errors++; $display("[TB] FAIL rnd_commit_tag@%0d: got %0h want %0h", cyc, bus.o_commit_tag, e_tag); end
      checks++; if (bus.o_commit_RegWrite !== e_rw) begin errors++; $display("[TB] FAIL rnd_regwrite@%0d: got %0h want %0h", cyc, bus.o_commit_RegWrite, e_rw); end
      checks++; if (bus.o_commit_rd !== e_rd) begin errors++; $display("[TB] FAIL rnd_commit_rd@%0d: got %0h want %0h", cyc, bus.o_commit_rd, e_rd); end
      checks++; if (bus.o_commit_data !== e_data) begin errors++; $display("[TB] FAIL rnd_commit_data@%0d: got %0h want %0h", cyc, bus.o_commit_data, e_data); end
      checks++; if (bus.o_q_done !== e_qd) begin errors++; $display("[TB] FAIL rnd_q_done@%0d: got %0h want %0h", cyc, bus.o_q_done, e_qd); end
      checks++; if (bus.o_q_data !== e_qdata) begin errors++; $display("[TB] FAIL rnd_q_data@%0d: got %0h want %0h", cyc, bus.o_q_data, e_qdata); end
      tick();
    end
    reset = 1'b1;
    idle_inputs();
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    test_reset();
    test_single();
    test_out_of_order();
    test_full_wrap();
    test_rd_zero();
    test_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
